// File: rtl/wb_stage.sv
// wb_stage: LC-3b writeback stage; regfile, nzp flags, retire counter.
// Consumes the MEM/WB payload and feeds bypassed reads back to decode.
//
// Ports:
//   clk, reset       core clock; async active-high reset
//   wb_valid         entry holds a real instruction (0 = bubble)
//   wb_ir, wb_pc     instruction word, PC+2
//   wb_mem, wb_alu   memory read word, ALU result / effective address
//   regfilemux_sel   00 ALU, 01 mem word, 10 mem byte, 11 PC
//   load_regfile     instruction writes a GPR
//   load_cc          instruction updates nzp
//   sr1_sel/sr2_sel  decode read addresses
//   sr1_out/sr2_out  bypassed read data
//   wb_data/dest/we  combinational writeback tuple for forwarding
//   cc_out           registered {n,z,p}
//   retired_count    retired-instruction counter (wraps)
module wb_stage #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wb_valid,
    input  logic [15:0]      wb_ir,
    input  logic [15:0]      wb_pc,
    input  logic [15:0]      wb_mem,
    input  logic [15:0]      wb_alu,
    input  logic [1:0]       regfilemux_sel,
    input  logic             load_regfile,
    input  logic             load_cc,
    input  logic [2:0]       sr1_sel,
    input  logic [2:0]       sr2_sel,
    output logic [15:0]      sr1_out,
    output logic [15:0]      sr2_out,
    output logic [15:0]      wb_data,
    output logic [2:0]       wb_dest,
    output logic             wb_we,
    output logic [2:0]       cc_out,
    output logic [CNT_W-1:0] retired_count
);

    logic [15:0]      r_gpr [8];
    logic [2:0]       r_cc;
    logic [CNT_W-1:0] r_cnt;

    logic [3:0]  w_opcode;
    logic        w_link;
    logic [2:0]  w_dest;
    logic [7:0]  w_byte;
    logic [15:0] w_byte_sext;
    logic [15:0] w_data;
    logic        w_we;
    logic        w_cc_we;
    logic        w_n;
    logic        w_z;
    logic        w_p;
    logic [2:0]  w_cc;
    logic        w_unused;

    // Only opcode and DR field matter here; the rest of IR is decode's.
    assign w_unused = ^wb_ir[8:0];

    assign w_opcode = wb_ir[15:12];

    // JSR/JSRR and TRAP link through R7 regardless of IR[11:9].
    assign w_link = (w_opcode == 4'b0100) || (w_opcode == 4'b1111);
    assign w_dest = w_link ? 3'd7 : wb_ir[11:9];

    // LDB: the low address bit picks the byte lane.
    assign w_byte      = wb_alu[0] ? wb_mem[15:8] : wb_mem[7:0];
    assign w_byte_sext = {{8{w_byte[7]}}, w_byte};

    always_comb begin
        w_data = wb_alu;
        unique case (regfilemux_sel)
            2'b00: w_data = wb_alu;
            2'b01: w_data = wb_mem;
            2'b10: w_data = w_byte_sext;
            2'b11: w_data = wb_pc;
            default: w_data = wb_alu;
        endcase
    end

    assign w_we    = wb_valid & load_regfile;
    assign w_cc_we = wb_valid & load_cc;

    // One-hot nzp derived from the value being written back.
    assign w_n  = w_data[15];
    assign w_z  = (w_data == 16'h0000);
    assign w_p  = !w_n && !w_z;
    assign w_cc = {w_n, w_z, w_p};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                r_gpr[i] <= 16'h0000;
            end
        end else if (w_we) begin
            r_gpr[w_dest] <= w_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cc <= 3'b010;
        end else if (w_cc_we) begin
            r_cc <= w_cc;
        end
    end

    // Counts every valid entry; a held valid entry counts again.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (wb_valid) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Same-cycle bypass so decode sees the value being written now.
    always_comb begin
        sr1_out = r_gpr[sr1_sel];
        if (w_we && (w_dest == sr1_sel)) begin
            sr1_out = w_data;
        end
    end

    always_comb begin
        sr2_out = r_gpr[sr2_sel];
        if (w_we && (w_dest == sr2_sel)) begin
            sr2_out = w_data;
        end
    end

    assign wb_data       = w_data;
    assign wb_dest       = w_dest;
    assign wb_we         = w_we;
    assign cc_out        = r_cc;
    assign retired_count = r_cnt;

endmodule
